muldiv_hilo_ctrl: RTL



---
 rtl/muldiv_hilo_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write
module muldiv_hilo_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_out
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      prod_q;
    logic [32:0]      rem_q;
    logic [31:0]      quot_q;
    logic [CNT_W-1:0] cnt_q;

    logic        accept;
    logic        div_last;
    logic [31:0] a_mag_in;
    logic [32:0] b_mag;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
    logic [63:0] result;

    assign accept   = (state == IDLE) && start && !flush;
    assign div_last = (cnt_q == CNT_W'(DIV_CYCLES - 1));

    // Operands are taken as magnitudes; 0x80000000 negates to itself and stays correct unsigned.
    assign a_mag_in = (!op[0] && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag    = {1'b0, ((!op_q[0] && b_q[31]) ? (32'd0 - b_q) : b_q)};

    assign prod_signed   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_unsigned = {32'd0, a_q} * {32'd0, b_q};

    // Remainder stays below the divisor magnitude, so the 33-bit trial keeps a valid sign bit.
    assign rem_shift = {rem_q[31:0], quot_q[31]};
    assign trial     = rem_shift - b_mag;

    assign quot_fixed = (!op_q[0] && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_q) : quot_q;
    assign rem_fixed  = (!op_q[0] && a_q[31]) ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    assign result     = op_q[1] ? {rem_fixed, quot_fixed} : prod_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_req  = 1'b0;
        busy       = (state != IDLE);
        hilo_we    = 1'b0;
        case (state)
            IDLE: begin
                stall_req = rst && start && !flush;
                if (accept) begin
                    state_next = op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                stall_req  = 1'b1;
                state_next = DONE;
            end
            DIV: begin
                stall_req = 1'b1;
                if (div_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                hilo_we    = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    assign hilo_out = hilo_we ? result : 64'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            prod_q <= 64'd0;
            rem_q  <= 33'd0;
            quot_q <= 32'd0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                a_q    <= src_a;
                b_q    <= src_b;
                quot_q <= a_mag_in;
                rem_q  <= 33'd0;
                cnt_q  <= '0;
            end else if (state == MUL) begin
                prod_q <= op_q[0] ? prod_unsigned : prod_signed;
            end else if (state == DIV) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!trial[32]) begin
                    rem_q  <= trial;
                    quot_q <= {quot_q[30:0], 1'b1};
                end else begin
                    rem_q  <= rem_shift;
                    quot_q <= {quot_q[30:0], 1'b0};
                end
            end
        end
    end

endmodule
